axi_read_slave: RTL

AXI read-side responder that completes the read path opposite the team's two-FIFO read master. It accepts AR requests into a 2-entry request queue and returns R bursts from an internal word-addressed memory, honouring FIXED, INCR and WRAP bursts. A backdoor write port lets the bench preload memory contents.

---
 rtl/axi_read_slave.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_read_slave.sv
// AXI read responder: 2-entry AR queue feeding an R-channel FSM that serves FIXED/INCR/WRAP
// bursts from a backdoor-loaded word memory. Define AXI_RS_DECERR_EN for per-beat DECERR past the memory end.
module axi_read_slave #(
  parameter int BusWidth = 32,
  parameter int tagbits  = 1,
  parameter int MemWords = 64
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  input  logic [tagbits-1:0]          ARID,
  input  logic [BusWidth-1:0]         ARADDR,
  input  logic [3:0]                  ARLEN,
  input  logic [1:0]                  ARSIZE,
  input  logic [1:0]                  ARBURST,
  input  logic [1:0]                  ARLOCK,
  input  logic [3:0]                  ARCACHE,
  input  logic [2:0]                  ARPROT,
  input  logic                        ARVALID,
  output logic                        ARREADY,
  output logic [tagbits-1:0]          RID,
  output logic [BusWidth-1:0]         RDATA,
  output logic [1:0]                  RRESP,
  output logic                        RLAST,
  output logic                        RVALID,
  input  logic                        RREADY,
  input  logic                        mem_we,
  input  logic [$clog2(MemWords)-1:0] mem_waddr,
  input  logic [BusWidth-1:0]         mem_wdata
);

  localparam int AW = $clog2(MemWords);
  localparam logic [BusWidth-1:0] ONE = 1;
  localparam logic [1:0] FIXED = 2'b00, WRAP = 2'b10;
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  typedef struct packed {
    logic [tagbits-1:0]  id;
    logic [BusWidth-1:0] addr;
    logic [3:0]          len;
    logic [1:0]          size;
    logic [1:0]          burst;
  } req_t;

  typedef enum logic {IDLE, BEAT} state_t;

  function automatic logic slverr(input req_t r);
    logic bad_wrap;
    bad_wrap = (r.burst == WRAP) &&
               (!(r.len inside {4'd1, 4'd3, 4'd7, 4'd15}) || ((r.addr & ((ONE << r.size) - ONE)) != '0));
    return (r.size == 2'b11) || (r.burst == 2'b11) || bad_wrap;
  endfunction

  function automatic logic [BusWidth-1:0] next_addr(input logic [BusWidth-1:0] a, input logic [1:0] sz,
                                                    input logic [1:0] bt, input logic [3:0] ln);
    logic [BusWidth-1:0] step, mask, res;
    step = ONE << sz;
    mask = ((BusWidth'(ln) + ONE) << sz) - ONE;
    case (bt)
      FIXED:   res = a;
      WRAP:    res = (a & ~mask) | ((a + step) & mask);
      default: res = a + step;
    endcase
    return res;
  endfunction

  logic unused_sideband;
  assign unused_sideband = ^{ARLOCK, ARCACHE, ARPROT};

  // Request queue
  req_t       q [2];
  logic       wr_ptr, rd_ptr, push, pop;
  logic [1:0] count, count_next;
  req_t       head;
  logic       head_err;

  assign push       = ARVALID && ARREADY;
  assign count_next = count + {1'b0, push} - {1'b0, pop};
  assign head       = q[rd_ptr];
  assign head_err   = slverr(head);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      ARREADY <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count   <= count_next;
      ARREADY <= (count_next < 2'd2);
    end
  end

  // NOTE: storage arrays carry no reset; validity is tracked by count/state, and memory must survive reset.
  always_ff @(posedge ACLK) begin
    if (push) q[wr_ptr] <= '{id: ARID, addr: ARADDR, len: ARLEN, size: ARSIZE, burst: ARBURST};
  end

  logic [BusWidth-1:0] mem [MemWords];

  always_ff @(posedge ACLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Burst registers describe the beat currently on (or about to go on) the R channel.
  state_t              state, state_next;
  logic [BusWidth-1:0] addr, addr_adv;
  logic [3:0]          beats_left, len;
  logic [tagbits-1:0]  id;
  logic [1:0]          size, burst;
  logic                err;
  logic                load, step_en, present, from_head, drop;

  assign addr_adv = next_addr(addr, size, burst, len);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load       = 1'b0;
    step_en    = 1'b0;
    present    = 1'b0;
    from_head  = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: if (count != 2'd0) begin
        pop        = 1'b1;
        load       = 1'b1;
        state_next = BEAT;
      end
      BEAT: begin
        if (!RVALID) begin
          present = 1'b1;
        end else if (RREADY) begin
          if (beats_left != 4'd0) begin
            step_en = 1'b1;
            present = 1'b1;
          end else if (count != 2'd0) begin
            pop       = 1'b1;
            load      = 1'b1;
            present   = 1'b1;
            from_head = 1'b1;
          end else begin
            drop       = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Next beat source: fresh head on a back-to-back pop, advanced address, or the loaded start.
  logic [BusWidth-1:0] src_addr, src_data;
  logic [3:0]          src_left;
  logic                src_err, src_oor;
  logic [tagbits-1:0]  src_id;
  logic [1:0]          src_resp;
  logic                unused_addr_bits;

  always_comb begin
    src_addr = addr;
    src_left = beats_left;
    src_err  = err;
    src_id   = id;
    if (from_head) begin
      src_addr = head.addr;
      src_left = head.len;
      src_err  = head_err;
      src_id   = head.id;
    end else if (step_en) begin
      src_addr = addr_adv;
      src_left = beats_left - 4'd1;
    end
  end

`ifdef AXI_RS_DECERR_EN
  assign src_oor = (src_addr >= BusWidth'(MemWords * 4));
`else
  assign src_oor = 1'b0;
`endif

  assign unused_addr_bits = ^{src_addr[BusWidth-1:AW+2], src_addr[1:0]};
  assign src_resp = src_err ? SLVERR : (src_oor ? DECERR : OKAY);
  assign src_data = (src_resp == OKAY) ? mem[src_addr[AW+1:2]] : '0;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      addr       <= '0;
      beats_left <= '0;
      len        <= '0;
      id         <= '0;
      size       <= '0;
      burst      <= '0;
      err        <= 1'b0;
      RVALID     <= 1'b0;
      RLAST      <= 1'b0;
      RID        <= '0;
      RDATA      <= '0;
      RRESP      <= OKAY;
    end else begin
      if (load) begin
        addr       <= head.addr;
        beats_left <= head.len;
        len        <= head.len;
        id         <= head.id;
        size       <= head.size;
        burst      <= head.burst;
        err        <= head_err;
      end else if (step_en) begin
        addr       <= addr_adv;
        beats_left <= beats_left - 4'd1;
      end
      if (present) begin
        RVALID <= 1'b1;
        RID    <= src_id;
        RDATA  <= src_data;
        RRESP  <= src_resp;
        RLAST  <= (src_left == 4'd0);
      end else if (drop) begin
        RVALID <= 1'b0;
        RLAST  <= 1'b0;
      end
    end
  end

endmodule
